ram64_seq: RTL and testbench
============================

RAM64_SEQ -- requirements
Module: ram64_seq

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set RAM address width; the word count is 2**ADDR_W (64 at default).
REQ-002 Parameter DATA_W, default 16, SHALL set data word width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL request a sweep; sampled only in IDLE.
REQ-006 mode  input  2  SHALL select the sweep type: 00 fill, 01 check, 10 clear, 11 reserved.
REQ-007 base_addr  input  ADDR_W  SHALL give the first address of the sweep.
REQ-008 count  input  ADDR_W+1  SHALL give the number of words to sweep.
REQ-009 pattern  input  DATA_W  SHALL give the seed data word.
REQ-010 ram_in  output  DATA_W  SHALL be write data to the RAM64 in port.
REQ-011 ram_load  output  1  SHALL be the write enable to RAM64 load.
REQ-012 ram_addr  output  ADDR_W  SHALL be the address to RAM64 address.
REQ-013 ram_out  input  DATA_W  SHALL be RAM64 combinational read data.
REQ-014 busy  output  1  SHALL be high while a sweep runs.
REQ-015 done  output  1  SHALL be a one-cycle completion pulse.
REQ-016 err  output  1  SHALL be a sticky check-mismatch flag.
REQ-017 err_addr  output  ADDR_W  SHALL hold the first mismatching address.
REQ-018 err_count  output  ADDR_W+1  SHALL hold the number of mismatches.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-020 IDLE with start=1 and mode!=11 at edge T SHALL load the parameters, clear err/err_addr/err_count, enter RUN, and set busy=1, ram_addr=base_addr.
REQ-021 Parameters SHALL be latched at start; input changes during RUN SHALL be ignored.
REQ-022 In RUN, word k (k=0..N-1) SHALL be presented for exactly one cycle at ram_addr=(base_addr+k) mod 64.
REQ-023 Fill mode SHALL drive ram_load=1 and ram_in=expected(k); clear mode SHALL drive ram_load=1 and ram_in=0.
REQ-024 Check mode SHALL hold ram_load=0 and compare ram_out with expected(k) in the same cycle.
REQ-025 On a check mismatch, err_count SHALL increment; the first mismatch SHALL set err=1 and capture err_addr.
REQ-026 Effective N: count=0 -> 0 words, so RUN is skipped and the FSM goes directly to DONE; count>64 -> clamp to 64.
REQ-027 After the last word the FSM SHALL enter DONE for one cycle with done=1, busy=0, ram_load=0, then return to IDLE.
REQ-028 An N-word sweep SHALL hold busy high for N cycles, and done SHALL assert on cycle N+1 after the start edge.
REQ-029 The address SHALL wrap 63->0 without a gap or stall.
REQ-030 start during RUN or DONE SHALL be ignored; start with mode=11 SHALL be ignored (no busy, no done).
REQ-031 err, err_addr and err_count SHALL hold until the next accepted start or reset; fill and clear sweeps SHALL also clear them.
REQ-032 ram_load SHALL never be high outside RUN.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, with ram_load=0, ram_in=0, ram_addr=0, busy=0, done=0, err=0, err_addr=0 and err_count=0, regardless of clk.
REQ-034 Reset during RUN SHALL abort the sweep with no done pulse; words already written SHALL remain in RAM.
REQ-035 After rst_n rises, the first rising edge SHALL be able to accept start.

Configuration
REQ-036 Macro RAM64_SEQ_INCR_EN defined: expected(k) SHALL be (pattern+k) mod 2**DATA_W.
REQ-037 Macro RAM64_SEQ_INCR_EN undefined: expected(k) SHALL be pattern for all k, and the incrementer SHALL be absent.

Verification
REQ-038 Fill base=33, count=2, pattern=12321 -> RAM[33]=12321 and RAM[34]=12321 (INCR_EN: 12322); busy 2 cycles; done on cycle 3.
REQ-039 Fill base=62, count=4 -> writes at 62, 63, 0, 1 in consecutive cycles; no other address written.
REQ-040 Fill 0..63 with 12321, then force RAM[5]=0 and RAM[40]=0, then check base=0 count=64 -> err=1, err_addr=5, err_count=2.
REQ-041 count=0 -> busy never high, done on the cycle after start; count=100 -> exactly 64 writes.
REQ-042 rst_n low mid-fill at k=10 -> ram_load drops asynchronously, no done pulse, RAM[base+10] unwritten.
REQ-043 start pulsed during RUN, and start with mode=11 in IDLE -> both ignored; sweep length is unchanged.

Source files
------------

// File: rtl/ram64_seq.sv
// RAM sweep sequencer: fills, checks or clears a window of a RAM64, tracking check mismatches.
// Define RAM64_SEQ_INCR_EN to step the data word by one per address; otherwise every word equals pattern.
module ram64_seq #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] pattern,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   err_count
);

  // state  | meaning
  // S_IDLE | waiting for an accepted start
  // S_RUN  | one word presented per cycle, rem_q words left after the current one
  // S_DONE | single-cycle completion, done pulse high
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0]        M_FILL  = 2'b00;
  localparam logic [1:0]        M_CHECK = 2'b01;
  localparam logic [1:0]        M_RSVD  = 2'b11;
  localparam logic [ADDR_W:0]   WORDS   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [DATA_W-1:0]   ram_in_q, ram_in_d;
  logic                ram_load_q, ram_load_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [ADDR_W:0]     err_count_q, err_count_d;
  logic [ADDR_W:0]     n_eff;
  logic [DATA_W-1:0]   exp_nxt;

`ifdef RAM64_SEQ_INCR_EN
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  assign exp_nxt = exp_q + DATA_ONE;
`else
  assign exp_nxt = exp_q;
`endif

  assign n_eff = (count > WORDS) ? WORDS : count;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ram_addr_d  = ram_addr_q;
    rem_d       = rem_q;
    exp_d       = exp_q;
    ram_in_d    = ram_in_q;
    ram_load_d  = ram_load_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (start && (mode != M_RSVD)) begin
          mode_d      = mode;
          exp_d       = pattern;
          ram_addr_d  = base_addr;
          err_d       = 1'b0;
          err_addr_d  = '0;
          err_count_d = '0;
          if (n_eff == '0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            ram_load_d = 1'b0;
            ram_in_d   = '0;
          end else begin
            state_d    = S_RUN;
            busy_d     = 1'b1;
            rem_d      = n_eff - CNT_ONE;
            ram_load_d = (mode != M_CHECK);
            ram_in_d   = (mode == M_FILL) ? pattern : '0;
          end
        end
      end
      S_RUN: begin
        // ram_out is combinational, so it reflects the word at ram_addr_q this cycle
        if ((mode_q == M_CHECK) && (ram_out != exp_q)) begin
          err_count_d = err_count_q + CNT_ONE;
          if (!err_q) begin
            err_d      = 1'b1;
            err_addr_d = ram_addr_q;
          end
        end
        if (rem_q == '0) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          ram_load_d = 1'b0;
          ram_in_d   = '0;
        end else begin
          rem_d      = rem_q - CNT_ONE;
          ram_addr_d = ram_addr_q + ADR_ONE;
          exp_d      = exp_nxt;
          ram_in_d   = (mode_q == M_FILL) ? exp_nxt : '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      ram_addr_q  <= '0;
      rem_q       <= '0;
      exp_q       <= '0;
      ram_in_q    <= '0;
      ram_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ram_addr_q  <= ram_addr_d;
      rem_q       <= rem_d;
      exp_q       <= exp_d;
      ram_in_q    <= ram_in_d;
      ram_load_q  <= ram_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign ram_in    = ram_in_q;
  assign ram_load  = ram_load_q;
  assign ram_addr  = ram_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ram64_seq.sv
// Scoreboard bench for ram64_seq: a behavioural RAM64 plus a reference model of sweep results.
module tb_ram64_seq;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int WORDS = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] pattern = '0;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [AW:0]   err_count;

  ram64_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .pattern(pattern), .ram_in(ram_in), .ram_load(ram_load),
    .ram_addr(ram_addr), .ram_out(ram_out), .busy(busy), .done(done), .err(err),
    .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM64 stand-in: combinational read, write on rising edge; poke lets the bench corrupt words
  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end
  assign ram_out = mem[ram_addr];

  typedef struct {
    logic [AW-1:0] addr;
    logic          load;
    logic [DW-1:0] data;
  } word_t;
  typedef struct {
    logic          err;
    logic [AW-1:0] err_addr;
    logic [AW:0]   err_count;
    int            done_cyc;
  } fin_t;
  word_t wq[$];
  fin_t  fq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] p, input int k);
`ifdef RAM64_SEQ_INCR_EN
    return p + DW'(k);
`else
    if (k < 0) return '0;
    return p;
`endif
  endfunction

  // Reference: what each sweep presents word by word, how it changes RAM, and its final flags
  task automatic model_sweep(input logic [1:0] m, input int b, input int cnt, input logic [DW-1:0] p,
                             input int sc, input int abort_k);
    int n;
    int nerr;
    int first;
    n = (cnt > WORDS) ? WORDS : cnt;
    nerr = 0;
    first = 0;
    for (int k = 0; k < n; k++) begin
      word_t w;
      int a;
      logic [DW-1:0] e;
      if (abort_k >= 0 && k > abort_k) break;
      a = (b + k) % WORDS;
      e = exp_word(p, k);
      w.addr = AW'(a);
      w.load = (m != 2'b01);
      w.data = (m == 2'b00) ? e : '0;
      wq.push_back(w);
      if (abort_k < 0 || k < abort_k) begin
        if (m == 2'b01) begin
          if (ref_mem[a] !== e) begin
            if (nerr == 0) first = a;
            nerr++;
          end
        end else begin
          ref_mem[a] = w.data;
        end
      end
    end
    if (abort_k < 0) begin
      fin_t f;
      f.err       = (nerr != 0);
      f.err_addr  = AW'(first);
      f.err_count = (AW+1)'(nerr);
      f.done_cyc  = sc + n;
      fq.push_back(f);
    end
  endtask

  always @(negedge clk) begin
    word_t w;
    fin_t  f;
    if (rst_n) begin
      checks++;
      if (ram_load && !busy) begin
        errors++;
        $display("FAIL load_outside_run: ram_load=1 with busy=0 at cycle %0d", cyc);
      end
      if (busy) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy: busy=1 at cycle %0d with no word expected", cyc);
        end else begin
          w = wq.pop_front();
          chk("word_addr", ram_addr, w.addr);
          chk("word_load", ram_load, w.load);
          if (w.load) chk("word_data", ram_in, w.data);
        end
      end
      if (done) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with no sweep pending", cyc);
        end else begin
          f = fq.pop_front();
          chk("done_cycle", cyc, f.done_cyc);
          chk("done_busy", busy, 1'b0);
          chk("done_load", ram_load, 1'b0);
          chk("done_words_left", wq.size(), 0);
          chk("done_err", err, f.err);
          chk("done_err_addr", err_addr, f.err_addr);
          chk("done_err_count", err_count, f.err_count);
        end
      end
    end
  end

  task automatic poke(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_addr = AW'(a);
    poke_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] m, input int b, input int cnt, input logic [DW-1:0] p,
                       input bit now, input int abort_k);
    if (!now) @(negedge clk);
    start = 1'b1;
    mode = m;
    base_addr = AW'(b);
    count = (AW+1)'(cnt);
    pattern = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_sweep(m, b, cnt, p, cyc, abort_k);
    mode = 2'($urandom);
    base_addr = AW'($urandom);
    count = (AW+1)'($urandom);
    pattern = DW'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen within 300 cycles", name);
    end
  endtask

  task automatic compare_mem(input string name);
    int diffs;
    int first;
    diffs = 0;
    first = -1;
    for (int a = 0; a < WORDS; a++) begin
      if (mem[a] !== ref_mem[a]) begin
        if (first < 0) first = a;
        diffs++;
      end
    end
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL %s: %0d RAM words differ from model, first at address %0d", name, diffs, first);
    end
  endtask

  logic [DW-1:0] exp34;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ram_load", ram_load, 1'b0);
    chk("rst_ram_in", ram_in, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_count", err_count, 0);
    for (int a = 0; a < WORDS; a++) poke(a, DW'($urandom));
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b00, 33, 2, 16'd12321, 1'b0, -1);
    wait_done("fill33");
`ifdef RAM64_SEQ_INCR_EN
    exp34 = 16'd12322;
`else
    exp34 = 16'd12321;
`endif
    chk("ram33", mem[33], 16'd12321);
    chk("ram34", mem[34], exp34);
    compare_mem("mem_fill33");

    issue(2'b00, 62, 4, DW'($urandom), 1'b0, -1);
    wait_done("fill_wrap");
    compare_mem("mem_fill_wrap");

    issue(2'b00, 0, 64, 16'd12321, 1'b0, -1);
    wait_done("fill_all");
    poke(5, '0);
    poke(40, '0);
    issue(2'b01, 0, 64, 16'd12321, 1'b0, -1);
    wait_done("check_all");
    chk("chk_err", err, 1'b1);
    chk("chk_err_addr", err_addr, 5);
    chk("chk_err_count", err_count, 2);

    @(negedge clk);
    start = 1'b1;
    mode = 2'b11;
    base_addr = 6'd7;
    count = 7'd10;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rsvd_busy", busy, 1'b0);
      chk("rsvd_done", done, 1'b0);
    end
    chk("hold_err", err, 1'b1);
    chk("hold_err_count", err_count, 2);

    issue(2'b00, 17, 0, DW'($urandom), 1'b0, -1);
    wait_done("count0");
    issue(2'b10, 10, 100, DW'($urandom), 1'b0, -1);
    wait_done("count100");
    compare_mem("mem_count100");

    issue(2'b00, 20, 30, DW'($urandom), 1'b0, -1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    mode = 2'b01;
    count = 7'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_in_run");
    start = 1'b1;
    mode = 2'b00;
    count = 7'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_in_done_busy", busy, 1'b0);
    compare_mem("mem_start_in_run");

    issue(2'b00, 50, 20, DW'($urandom), 1'b0, 10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_load", ram_load, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_addr", ram_addr, 0);
    wq.delete();
    fq.delete();
    repeat (2) @(negedge clk);
    chk("abort_unwritten", mem[60], ref_mem[60]);
    rst_n = 1'b1;
    issue(2'b00, 0, 8, DW'($urandom), 1'b1, -1);
    wait_done("after_reset");
    compare_mem("mem_after_reset");

    for (int it = 0; it < 30; it++) begin
      int sel;
      int cnt;
      int npoke;
      sel = int'($urandom_range(0, 9));
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(1, 64));
      if (sel == 9) begin
        @(negedge clk);
        start = 1'b1;
        mode = 2'b11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
      end else if (sel <= 3) begin
        issue(2'b00, int'($urandom_range(0, 63)), cnt, DW'($urandom), 1'b0, -1);
        wait_done("rand_fill");
      end else if (sel <= 6) begin
        npoke = int'($urandom_range(0, 2));
        for (int j = 0; j < npoke; j++) poke(int'($urandom_range(0, 63)), DW'($urandom));
        issue(2'b01, int'($urandom_range(0, 63)), cnt, (sel == 6) ? DW'($urandom) : 16'd12321, 1'b0, -1);
        wait_done("rand_check");
      end else begin
        issue(2'b10, int'($urandom_range(0, 63)), cnt, DW'($urandom), 1'b0, -1);
        wait_done("rand_clear");
      end
      compare_mem("mem_random");
    end

    repeat (4) @(negedge clk);
    chk("queue_words_left", wq.size(), 0);
    chk("queue_done_left", fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
